gpmc_sync_master: RTL
=====================

# gpmc_sync_master

Synchronous GPMC bus initiator that drives the multiplexed address/data GPMC bus, for FPGA-side bench and loopback use against the on-chip GPMC SRAM responder and its 11-bit × 16-bit block RAM. It accepts single-word read and write requests on a valid/ready port and sequences the address phase, the data phase and bus turnaround with a state machine. It returns one response per transaction.

## Interface
Parameters:
- RD_LATENCY, 3: read wait cycles from OE assertion to data sample; legal range 1..15.
- WR_HOLD, 1: write data-phase length in cycles; legal range 1..15.
- TURN_CYCLES, 1: cycles with CS deasserted after each transaction; legal range 1..15.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- GPMC_CLK, in, 1: the single clock; every register is rising-edge triggered.
- GPMC_RST_N, in, 1: asynchronous active-low reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: high only in IDLE.
- req_wr, in, 1: 1 = write, 0 = read.
- req_addr, in, 11: word address.
- req_wdata, in, 16: write data.
- req_be, in, 2: byte enables, active high; bit 0 covers bits 7:0.
- rsp_valid, out, 1: one-cycle completion pulse, one per transaction.
- rsp_rdata, out, 16: read data; holds its value across writes.
- GPMC_AD_OUT, out, 16: address/data driven onto the bus.
- GPMC_AD_OE, out, 1: pad output enable for GPMC_AD_OUT.
- GPMC_AD_IN, in, 16: bus sampled during reads.
- GPMC_CS, out, 1: chip select, active low.
- GPMC_ADV, out, 1: address valid, active high.
- GPMC_OE, out, 1: output enable, active low.
- GPMC_WE, out, 1: write enable, active low.
- GPMC_BE0, out, 1: byte enable for bits 7:0, active low.
- GPMC_BE1, out, 1: byte enable for bits 15:8, active low.
- GPMC_WP, out, 1: constant 1, meaning not write-protected.
- GPMC_DIR, out, 1: 1 = responder drives the bus.

## Operation
- Acceptance:
  - A request is accepted on a rising edge where req_valid & req_ready.
  - req_wr, req_addr, req_wdata and req_be are captured into registers at that edge.
  - Request inputs are ignored outside acceptance.
- IDLE:
  - Outputs: CS=1, ADV=0, OE=1, WE=1, BE0=BE1=1, DIR=0, AD_OE=0, AD_OUT=0, req_ready=1.
  - On acceptance, go to ADDR.
- ADDR (1 cycle):
  - Outputs: CS=0, ADV=1, AD_OE=1, AD_OUT={5'b0, addr}.
  - Next state is DATA for a write, RWAIT for a read.
- DATA (WR_HOLD cycles):
  - Outputs: CS=0, ADV=0, WE=0, BE0=~be[0], BE1=~be[1], AD_OE=1, AD_OUT=wdata.
  - Next state is TURN.
- RWAIT (RD_LATENCY cycles):
  - Outputs: CS=0, ADV=0, OE=0, DIR=1, AD_OE=0, BE0=BE1=0.
  - At the edge that ends the last RWAIT cycle, register GPMC_AD_IN into rsp_rdata.
  - Next state is TURN.
- TURN (TURN_CYCLES cycles):
  - All bus outputs at IDLE levels.
  - Next state is IDLE.
- rsp_valid:
  - Asserted during the first TURN cycle for both reads and writes.
  - rsp_rdata is already valid in that cycle for reads.
- Phase counter:
  - Loaded with (phase length − 1) on entry to DATA, RWAIT and TURN.
  - Decrements each cycle; the state exits when the counter is 0.
- AD_OE and DIR are never 1 at the same time. Bus contention is a design error.
- Reset (also mid-transaction):
  - Immediately forces IDLE and IDLE output levels.
  - rsp_valid=0, rsp_rdata=0.
  - The counter is set to 0.
  - An interrupted transaction produces no response.

## Timing
- Cycle 0 is the cycle after acceptance.
- Write: ADDR at cycle 0, DATA at cycles 1..WR_HOLD, then TURN. req_ready returns after 1+WR_HOLD+TURN_CYCLES cycles; with defaults, 3 cycles.
- Read: ADDR at cycle 0, RWAIT at cycles 1..RD_LATENCY, then TURN. req_ready returns after 1+RD_LATENCY+TURN_CYCLES cycles; with defaults, 5 cycles.
- Back-to-back requests are separated by at least one IDLE cycle plus TURN.
- The default RD_LATENCY=3 matches the responder, which registers the address, then does the RAM read, then registers the output.

## Configuration
- Macro: GPMC_SYNC_MASTER_WAIT_EN.
- Defined:
  - Adds input port GPMC_WAIT (1 bit, active high).
  - While GPMC_WAIT=1 in RWAIT or DATA, the phase counter holds and the state does not advance.
  - Sampling and write completion are delayed by one cycle per stalled cycle.
- Undefined:
  - The GPMC_WAIT port is absent.
  - Phase lengths are fixed by the parameters.

## Structure
- Package gpmc_pkg holds:
  - the state enum (IDLE, ADDR, DATA, RWAIT, TURN);
  - GPMC_ADDR_W=11 and GPMC_DATA_W=16;
  - constants for the idle levels of CS, ADV, OE, WE, BE and DIR.
- Sub-module gpmc_phase_counter: a 4-bit loadable down-counter with hold input and zero flag. It is instantiated once and shared by all phases.

## Test plan
- Reset: assert GPMC_RST_N=0 mid-RWAIT -> CS=1, OE=1, AD_OE=0 immediately; rsp_valid never pulses; req_ready=1 after release.
- Write, defaults: addr=0x123, wdata=0xBEEF, be=2'b11 -> ADDR cycle shows AD_OUT=0x0123 with ADV=1. Next cycle WE=0, BE0=BE1=0, AD_OUT=0xBEEF. rsp_valid pulses at cycle 2; req_ready=1 at cycle 3.
- Read against the responder: write 0xA5C3 to 0x7FF, then read 0x7FF -> rsp_rdata=0xA5C3 with rsp_valid at cycle 4.
- Byte enables: be=2'b01 -> BE0=0, BE1=1 during DATA.
- Parameters: RD_LATENCY=1, TURN_CYCLES=3 -> OE low for exactly 1 cycle, CS high for exactly 3 cycles. Throughout, AD_OE&DIR is never 1.
- With GPMC_SYNC_MASTER_WAIT_EN, hold GPMC_WAIT=1 for 4 cycles in RWAIT -> the sample and rsp_valid are delayed by exactly 4 cycles, and the data is still correct.

Source files
------------

// File: rtl/gpmc_pkg.sv
// gpmc_pkg: shared types and constants for the synchronous GPMC initiator.
// Holds the FSM state encoding, bus widths and the idle levels of every
// GPMC control strobe.
package gpmc_pkg;

  localparam int unsigned GPMC_ADDR_W = 11;
  localparam int unsigned GPMC_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    RWAIT,
    TURN
  } gpmc_state_e;

  // Strobe levels while the bus is parked
  localparam logic CS_IDLE  = 1'b1;
  localparam logic ADV_IDLE = 1'b0;
  localparam logic OE_IDLE  = 1'b1;
  localparam logic WE_IDLE  = 1'b1;
  localparam logic BE_IDLE  = 1'b1;
  localparam logic DIR_IDLE = 1'b0;

  typedef struct packed {
    logic                   cs;
    logic                   adv;
    logic                   oe;
    logic                   we;
    logic                   be0;
    logic                   be1;
    logic                   dir;
    logic                   ad_oe;
    logic [GPMC_DATA_W-1:0] ad_out;
  } gpmc_bus_t;

  localparam gpmc_bus_t BUS_IDLE = '{
    cs:     CS_IDLE,
    adv:    ADV_IDLE,
    oe:     OE_IDLE,
    we:     WE_IDLE,
    be0:    BE_IDLE,
    be1:    BE_IDLE,
    dir:    DIR_IDLE,
    ad_oe:  1'b0,
    ad_out: '0
  };

endpackage

// File: rtl/gpmc_sync_master_if.sv
// gpmc_sync_master_if: request/response port plus the multiplexed GPMC pins.
// The master modport is the initiator's view; slave is the opposite side.
interface gpmc_sync_master_if import gpmc_pkg::*; ();

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_wr;
  logic [GPMC_ADDR_W-1:0] req_addr;
  logic [GPMC_DATA_W-1:0] req_wdata;
  logic [1:0]             req_be;
  logic                   rsp_valid;
  logic [GPMC_DATA_W-1:0] rsp_rdata;

  logic [GPMC_DATA_W-1:0] GPMC_AD_OUT;
  logic                   GPMC_AD_OE;
  logic [GPMC_DATA_W-1:0] GPMC_AD_IN;
  logic                   GPMC_CS;
  logic                   GPMC_ADV;
  logic                   GPMC_OE;
  logic                   GPMC_WE;
  logic                   GPMC_BE0;
  logic                   GPMC_BE1;
  logic                   GPMC_WP;
  logic                   GPMC_DIR;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, req_be, GPMC_AD_IN,
    output req_ready, rsp_valid, rsp_rdata,
    output GPMC_AD_OUT, GPMC_AD_OE, GPMC_CS, GPMC_ADV, GPMC_OE, GPMC_WE,
    output GPMC_BE0, GPMC_BE1, GPMC_WP, GPMC_DIR
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, req_be, GPMC_AD_IN,
    input  req_ready, rsp_valid, rsp_rdata,
    input  GPMC_AD_OUT, GPMC_AD_OE, GPMC_CS, GPMC_ADV, GPMC_OE, GPMC_WE,
    input  GPMC_BE0, GPMC_BE1, GPMC_WP, GPMC_DIR
  );

endinterface

// File: rtl/gpmc_phase_counter.sv
// gpmc_phase_counter: 4-bit loadable down-counter shared by all bus phases.
// Stops at zero so it idles at 0 between transactions.
module gpmc_phase_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       hold,
  output logic       zero
);

  logic [3:0] count;

  // Load has priority over hold; otherwise count down towards zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!hold && (count != '0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gpmc_sync_master.sv
// gpmc_sync_master: synchronous GPMC initiator on a multiplexed AD bus.
// Sequences ADDR -> DATA (write) or RWAIT (read) -> TURN, one response per
// transaction. Define GPMC_SYNC_MASTER_WAIT_EN to add the GPMC_WAIT stall input.
module gpmc_sync_master import gpmc_pkg::*; #(
  parameter int unsigned RD_LATENCY  = 3,
  parameter int unsigned WR_HOLD     = 1,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic GPMC_CLK,
  input  logic GPMC_RST_N,
`ifdef GPMC_SYNC_MASTER_WAIT_EN
  input  logic GPMC_WAIT,
`endif
  gpmc_sync_master_if.master bus
);

  localparam logic [3:0] RD_LEN   = 4'(RD_LATENCY - 1);
  localparam logic [3:0] WR_LEN   = 4'(WR_HOLD - 1);
  localparam logic [3:0] TURN_LEN = 4'(TURN_CYCLES - 1);

  gpmc_state_e            state, state_nxt;
  gpmc_bus_t              bus_q, bus_nxt;
  logic                   wr_r;
  logic [GPMC_ADDR_W-1:0] addr_r;
  logic [GPMC_DATA_W-1:0] wdata_r;
  logic [1:0]             be_r;
  logic                   ready_q;
  logic                   rsp_valid_q;
  logic [GPMC_DATA_W-1:0] rsp_rdata_q;
  logic                   accept;
  logic                   stall;
  logic                   cnt_load;
  logic [3:0]             cnt_val;
  logic                   cnt_hold;
  logic                   cnt_zero;

`ifdef GPMC_SYNC_MASTER_WAIT_EN
  assign stall = GPMC_WAIT;
`else
  assign stall = 1'b0;
`endif

  assign accept = (state == IDLE) && bus.req_valid;

  gpmc_phase_counter u_phase_cnt (
    .clk      (GPMC_CLK),
    .rst_n    (GPMC_RST_N),
    .load     (cnt_load),
    .load_val (cnt_val),
    .hold     (cnt_hold),
    .zero     (cnt_zero)
  );

  // Next-state and phase-counter control
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_hold  = 1'b0;
    unique case (state)
      IDLE: if (accept) state_nxt = ADDR;
      ADDR: begin
        state_nxt = wr_r ? DATA : RWAIT;
        cnt_load  = 1'b1;
        cnt_val   = wr_r ? WR_LEN : RD_LEN;
      end
      DATA, RWAIT: begin
        if (stall) begin
          cnt_hold = 1'b1;
        end else if (cnt_zero) begin
          state_nxt = TURN;
          cnt_load  = 1'b1;
          cnt_val   = TURN_LEN;
        end
      end
      TURN: if (cnt_zero) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus levels for the state being entered, so the pins come straight from flops.
  // ADDR is only entered from IDLE on acceptance, hence the raw req_addr there.
  always_comb begin
    bus_nxt = BUS_IDLE;
    unique case (state_nxt)
      ADDR: begin
        bus_nxt.cs     = 1'b0;
        bus_nxt.adv    = 1'b1;
        bus_nxt.ad_oe  = 1'b1;
        bus_nxt.ad_out = {{(GPMC_DATA_W - GPMC_ADDR_W){1'b0}}, bus.req_addr};
      end
      DATA: begin
        bus_nxt.cs     = 1'b0;
        bus_nxt.we     = 1'b0;
        bus_nxt.be0    = ~be_r[0];
        bus_nxt.be1    = ~be_r[1];
        bus_nxt.ad_oe  = 1'b1;
        bus_nxt.ad_out = wdata_r;
      end
      RWAIT: begin
        bus_nxt.cs  = 1'b0;
        bus_nxt.oe  = 1'b0;
        bus_nxt.dir = 1'b1;
        bus_nxt.be0 = 1'b0;
        bus_nxt.be1 = 1'b0;
      end
      default: bus_nxt = BUS_IDLE;
    endcase
  end

  // FSM state, request capture, registered pins and response
  always_ff @(posedge GPMC_CLK or negedge GPMC_RST_N) begin
    if (!GPMC_RST_N) begin
      state       <= IDLE;
      bus_q       <= BUS_IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      wr_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      be_r        <= '0;
    end else begin
      state       <= state_nxt;
      bus_q       <= bus_nxt;
      ready_q     <= (state_nxt == IDLE);
      rsp_valid_q <= (state != TURN) && (state_nxt == TURN);
      if ((state == RWAIT) && (state_nxt == TURN)) rsp_rdata_q <= bus.GPMC_AD_IN;
      if (accept) begin
        wr_r    <= bus.req_wr;
        addr_r  <= bus.req_addr;
        wdata_r <= bus.req_wdata;
        be_r    <= bus.req_be;
      end
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.GPMC_AD_OUT = bus_q.ad_out;
  assign bus.GPMC_AD_OE  = bus_q.ad_oe;
  assign bus.GPMC_CS     = bus_q.cs;
  assign bus.GPMC_ADV    = bus_q.adv;
  assign bus.GPMC_OE     = bus_q.oe;
  assign bus.GPMC_WE     = bus_q.we;
  assign bus.GPMC_BE0    = bus_q.be0;
  assign bus.GPMC_BE1    = bus_q.be1;
  assign bus.GPMC_DIR    = bus_q.dir;
  assign bus.GPMC_WP     = 1'b1;

endmodule
